ed_alif_syn_frontend: RTL

- Synaptic front-end that sits directly upstream of the ED-ALIF neuron and drives its I_syn, input_event, enable and refract_cnt inputs.
- Accepts addressed input spike events on a valid/ready interface and buffers them in a small FIFO.
- Looks up a programmable signed weight per synapse and accumulates weights into a saturating current for the current timestep.
- On each timestep tick, issues one neuron update and maintains the refractory counter from the neuron's spike feedback.

---
 rtl/ed_alif_syn_frontend.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ed_alif_syn_frontend.sv
// Synaptic front-end for the ED-ALIF neuron: buffers addressed spike events,
// accumulates signed weights into a saturating current and issues one neuron update per tick.
module ed_alif_syn_frontend #(
  parameter int         V_WIDTH        = 12,
  parameter int         SYN_W_WIDTH    = 8,
  parameter int         ADDR_WIDTH     = 4,
  parameter int         FIFO_DEPTH     = 4,
  parameter logic [3:0] REFRACT_PERIOD = 4'd3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic [ADDR_WIDTH-1:0]         ev_addr,
  input  logic                          wt_we,
  input  logic [ADDR_WIDTH-1:0]         wt_addr,
  input  logic [SYN_W_WIDTH-1:0]        wt_data,
  input  logic                          tick,
  input  logic                          spike_in,
  output logic                          enable,
  output logic signed [V_WIDTH-1:0]     I_syn,
  output logic                          input_event,
  output logic [3:0]                    refract_cnt,
  output logic                          tick_overrun
);

  localparam int unsigned N_WT  = 1 << ADDR_WIDTH;
  localparam int          PTR_W = $clog2(FIFO_DEPTH);
  localparam int          EXT   = V_WIDTH + 1 - SYN_W_WIDTH;

  localparam logic [V_WIDTH-1:0] ACC_MAX = {1'b0, {(V_WIDTH-1){1'b1}}};
  localparam logic [V_WIDTH-1:0] ACC_MIN = {1'b1, {(V_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SYN_W_WIDTH-1:0] wt_mem   [N_WT];
  logic [ADDR_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr, rd_ptr;
  logic                   fifo_empty, fifo_full;
  logic                   push, pop;
  logic [ADDR_WIDTH-1:0]  pop_addr;
  logic [SYN_W_WIDTH-1:0] pop_wt;

  logic [V_WIDTH-1:0]     acc, acc_next;
  logic [V_WIDTH:0]       acc_sum;
  logic                   evt_seen;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign ev_ready = (state == ACCUM) && !fifo_full;
  assign push     = ev_valid && ev_ready;
  assign pop      = !fifo_empty && ((state == ACCUM) || (state == DRAIN));
  assign pop_addr = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign pop_wt   = wt_mem[pop_addr];

  // One guard bit: overflow shows up as the top two sum bits disagreeing.
  assign acc_sum = {acc[V_WIDTH-1], acc} + {{EXT{pop_wt[SYN_W_WIDTH-1]}}, pop_wt};

  always_comb begin
    acc_next = acc_sum[V_WIDTH-1:0];
    if (acc_sum[V_WIDTH] != acc_sum[V_WIDTH-1]) begin
      acc_next = acc_sum[V_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (tick) state_next = DRAIN;
      DRAIN:   if (fifo_empty) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Weight table: a read in the same cycle as a write sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_WT; i++) begin
        wt_mem[i] <= '0;
      end
    end else if (wt_we) begin
      wt_mem[wt_addr] <= wt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= ev_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      evt_seen <= 1'b0;
    end else if (state == ISSUE) begin
      acc      <= '0;
      evt_seen <= 1'b0;
    end else if (pop) begin
      acc      <= acc_next;
      evt_seen <= 1'b1;
    end
  end

  // DRAIN only exits with the FIFO empty, so acc is final when ISSUE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable      <= 1'b0;
      I_syn       <= '0;
      input_event <= 1'b0;
    end else begin
      enable <= (state_next == ISSUE);
      if ((state != ISSUE) && (state_next == ISSUE)) begin
        I_syn       <= acc;
        input_event <= evt_seen;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refract_cnt <= '0;
    end else if (state == WAIT) begin
      if (spike_in) begin
        refract_cnt <= REFRACT_PERIOD;
      end else if (refract_cnt != '0) begin
        refract_cnt <= refract_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_overrun <= 1'b0;
    end else if (tick && (state != ACCUM)) begin
      tick_overrun <= 1'b1;
    end
  end

endmodule
